// File: rtl/uart_rx_bit_sampler.sv
// UART receive front end: counts oversampling edges and frame bits, and takes a
// three-sample majority vote around the middle of each bit.
module uart_rx_bit_sampler #(
  parameter int Data_width = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX_IN,
  input  logic [5:0] Prescale,
  input  logic       PAR_EN,
  input  logic       sampler_enable,
  output logic [5:0] edge_cnt,
  output logic [3:0] bit_cnt,
  output logic       sampled_bit,
  output logic       sample_valid,
  output logic       start_glitch,
  output logic       frame_done
);

  localparam logic [3:0] LAST_BASE = 4'(Data_width + 1);

  logic [5:0] p_r;
  logic       par_en_r;
  logic       s0_r;
  logic       s1_r;
  logic [5:0] p_legal_s;
  logic [5:0] half_s;
  logic [3:0] last_s;
  logic       vote_s;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Configuration decode and the mid-bit vote
  always_comb begin
    p_legal_s = 6'd8;
    case (Prescale)
      6'd8, 6'd16, 6'd32: p_legal_s = Prescale;
      default:            p_legal_s = 6'd8;
    endcase
    half_s = {1'b0, p_r[5:1]};
    last_s = LAST_BASE + {3'b000, par_en_r};
    vote_s = majority3(s0_r, s1_r, RX_IN);
  end

  // Edge/bit counters, sample capture and result strobes
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      p_r          <= 6'd8;
      par_en_r     <= 1'b0;
      s0_r         <= 1'b1;
      s1_r         <= 1'b1;
      edge_cnt     <= 6'd0;
      bit_cnt      <= 4'd0;
      sampled_bit  <= 1'b1;
      sample_valid <= 1'b0;
      start_glitch <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      start_glitch <= 1'b0;
      frame_done   <= 1'b0;
      if (!sampler_enable) begin
        // Configuration is only sampled between frames
        p_r      <= p_legal_s;
        par_en_r <= PAR_EN;
        edge_cnt <= 6'd0;
        bit_cnt  <= 4'd0;
        s0_r     <= 1'b0;
        s1_r     <= 1'b0;
      end else begin
        if (edge_cnt == p_r - 6'd1) begin
          edge_cnt <= 6'd0;
          if (bit_cnt == last_s) begin
            bit_cnt    <= 4'd0;
            frame_done <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
          end
        end else begin
          edge_cnt <= edge_cnt + 6'd1;
        end

        if (edge_cnt == half_s - 6'd1) begin
          s0_r <= RX_IN;
        end
        if (edge_cnt == half_s) begin
          s1_r <= RX_IN;
        end
        if (edge_cnt == half_s + 6'd1) begin
          sampled_bit  <= vote_s;
          sample_valid <= 1'b1;
          // A high start bit means the falling edge was noise: abort and re-count
          if ((bit_cnt == 4'd0) && vote_s) begin
            start_glitch <= 1'b1;
            edge_cnt     <= 6'd0;
            bit_cnt      <= 4'd0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_bit_sampler.sv
// Randomised frames checked cycle by cycle against an arithmetic model of the
// sampler derived from cycle position, bit period and the serial line contents.
module tb_uart_rx_bit_sampler;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_IN;
  logic [5:0] Prescale;
  logic       PAR_EN;
  logic       sampler_enable;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       sampled_bit;
  logic       sample_valid;
  logic       start_glitch;
  logic       frame_done;

  int   n_vec = 0;
  int   n_err = 0;
  logic sb_m;
  logic line_q[$];

  always #5 CLK = ~CLK;

  uart_rx_bit_sampler #(.Data_width(8)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .Prescale(Prescale), .PAR_EN(PAR_EN),
    .sampler_enable(sampler_enable), .edge_cnt(edge_cnt), .bit_cnt(bit_cnt),
    .sampled_bit(sampled_bit), .sample_valid(sample_valid),
    .start_glitch(start_glitch), .frame_done(frame_done)
  );

  task automatic check_vec(input string tag, input logic [13:0] act, input logic [13:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got edge=%0d bit=%0d sb/sv/sg/fd=%b, expected edge=%0d bit=%0d sb/sv/sg/fd=%b",
               tag, $time, act[13:8], act[7:4], act[3:0], exp[13:8], exp[7:4], exp[3:0]);
    end
  endtask

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (int'(a) + int'(b) + int'(c)) >= 2;
  endfunction

  function automatic logic [13:0] pack_exp(input int e, input int b, input logic sb,
                                           input logic sv, input logic sg, input logic fd);
    return {e[5:0], b[3:0], sb, sv, sg, fd};
  endfunction

  function automatic logic [13:0] obs();
    return {edge_cnt, bit_cnt, sampled_bit, sample_valid, start_glitch, frame_done};
  endfunction

  // Line level for every cycle of a frame: bit value per bit period, optional random flips
  task automatic build_line(input int p, input int last, input logic [10:0] bits, input int noise_pct);
    line_q.delete();
    for (int c = 0; c < (last + 1) * p + 8; c++) begin
      int   b;
      logic v;
      b = c / p;
      v = (b <= last) ? bits[b] : 1'b1;
      if (int'($urandom_range(99)) < noise_pct) v = ~v;
      line_q.push_back(v);
    end
  endtask

  // Cycle 0 is the first enabled cycle; enable held for n cycles, then checked idle
  task automatic run_frame(input string tag, input logic [5:0] pres, input logic par,
                           input int p, input int last, input int n_req,
                           input logic [5:0] mid_pres, input bit en_first);
    int   h, g, n, k, e, b;
    logic sv, sg, fd;
    bit   glitch;
    h      = p / 2;
    g      = h + 2;
    glitch = maj3(line_q[h-1], line_q[h], line_q[h+1]) && (n_req > h + 1);
    n      = (glitch && n_req > h + 5) ? h + 5 : n_req;
    if (!en_first) begin
      sampler_enable = 1'b0;
      Prescale       = pres;
      PAR_EN         = par;
      RX_IN          = 1'b1;
      repeat (2) begin
        check_vec({tag, "/idle"}, obs(), pack_exp(0, 0, sb_m, 1'b0, 1'b0, 1'b0));
        @(posedge CLK); #1;
      end
    end
    for (int c = 0; c <= n + 2; c++) begin
      sv = 1'b0; sg = 1'b0; fd = 1'b0;
      if (c > n) begin
        e = 0; b = 0;
      end else if (glitch && c >= g) begin
        k = c - g;
        e = k % p;
        b = (k / p) % (last + 1);
        if (k == 0) begin
          sv = 1'b1; sg = 1'b1; sb_m = 1'b1;
        end
      end else begin
        e = c % p;
        b = (c / p) % (last + 1);
        if (e == h + 2) begin
          sv   = 1'b1;
          sb_m = maj3(line_q[c-3], line_q[c-2], line_q[c-1]);
        end
        fd = (c > 0) && (c % ((last + 1) * p) == 0);
      end
      check_vec(tag, obs(), pack_exp(e, b, sb_m, sv, sg, fd));
      sampler_enable = (c < n);
      RX_IN          = (c < n) ? line_q[c] : 1'b1;
      if (mid_pres != 6'd0 && c >= 10 && c < n) begin
        Prescale = mid_pres;
        PAR_EN   = ~par;
      end else begin
        Prescale = pres;
        PAR_EN   = par;
      end
      @(posedge CLK); #1;
    end
  endtask

  initial begin
    logic [7:0]  data;
    logic [5:0]  pres;
    logic        par;
    int          p, last, full, n_req;
    RST = 1'b0; sampler_enable = 1'b0; Prescale = 6'd16; PAR_EN = 1'b1; RX_IN = 1'b1;
    sb_m = 1'b1;

    repeat (4) begin
      @(posedge CLK); #1;
      RX_IN = ~RX_IN;
      check_vec("reset", obs(), pack_exp(0, 0, 1'b1, 1'b0, 1'b0, 1'b0));
    end
    @(posedge CLK); #1;
    RST = 1'b1; RX_IN = 1'b1;
    repeat (3) begin
      @(posedge CLK); #1;
      check_vec("post_reset_idle", obs(), pack_exp(0, 0, 1'b1, 1'b0, 1'b0, 1'b0));
    end

    build_line(8, 10, {1'b1, 1'b0, 8'hA5, 1'b0}, 0);
    run_frame("clean_a5", 6'd8, 1'b1, 8, 10, 88, 6'd0, 1'b0);

    build_line(16, 10, {1'b1, 1'b0, 8'h0C, 1'b0}, 0);
    line_q[55] = 1'b1; line_q[56] = 1'b0; line_q[57] = 1'b0;
    line_q[73] = 1'b0;
    run_frame("majority", 6'd16, 1'b1, 16, 10, 176, 6'd0, 1'b0);

    build_line(32, 10, {1'b1, 1'b0, 8'h00, 1'b0}, 0);
    for (int c = 0; c < 32; c++) line_q[c] = (c >= 15);
    run_frame("start_glitch", 6'd32, 1'b1, 32, 10, 352, 6'd0, 1'b0);

    build_line(8, 9, {2'b11, 8'h3C, 1'b0}, 0);
    run_frame("illegal_pres", 6'd20, 1'b0, 8, 9, 80, 6'd0, 1'b0);

    build_line(8, 9, {2'b11, 8'h5A, 1'b0}, 0);
    run_frame("mid_cfg", 6'd8, 1'b0, 8, 9, 80, 6'd32, 1'b0);

    build_line(8, 10, {1'b1, ^8'h96, 8'h96, 1'b0}, 0);
    run_frame("drop_enable", 6'd8, 1'b1, 8, 10, 37, 6'd0, 1'b0);

    sampler_enable = 1'b1; Prescale = 6'd8; PAR_EN = 1'b0; RX_IN = 1'b0;
    repeat (20) @(posedge CLK);
    #4 RST = 1'b0;
    #1 check_vec("async_reset", obs(), pack_exp(0, 0, 1'b1, 1'b0, 1'b0, 1'b0));
    sb_m = 1'b1;
    @(posedge CLK); #1;
    Prescale = 6'd16; PAR_EN = 1'b1;
    build_line(8, 9, {2'b11, 8'hC3, 1'b0}, 0);
    RST = 1'b1;
    run_frame("after_reset", 6'd16, 1'b1, 8, 9, 80, 6'd0, 1'b1);

    repeat (8) begin
      case ($urandom_range(3))
        0:       pres = 6'd8;
        1:       pres = 6'd16;
        2:       pres = 6'd32;
        default: pres = 6'($urandom_range(63));
      endcase
      p     = (pres == 6'd8 || pres == 6'd16 || pres == 6'd32) ? int'(pres) : 8;
      par   = 1'($urandom);
      data  = 8'($urandom);
      last  = 9 + int'(par);
      full  = (last + 1) * p;
      n_req = ($urandom_range(1) == 1) ? full : int'($urandom_range(full, 1));
      build_line(p, last, {1'b1, par ? ^data : 1'b1, data, 1'b0}, 4);
      run_frame("random", pres, par, p, last, n_req,
                ($urandom_range(1) == 1) ? 6'($urandom) : 6'd0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
